// File: rtl/posit_fma_out_pipe.sv
// posit_fma_out_pipe: elastic, flushable retiming registers behind the posit FMA
package posit_pkg;
  typedef enum logic [1:0] {POSIT32, POSIT16, POSIT8, POSIT64} posit_format_e;
  typedef logic [4:0] status_t;
  function automatic int unsigned posit_width(posit_format_e f);
    return f == POSIT16 ? 16 : f == POSIT8 ? 8 : f == POSIT64 ? 64 : 32;
  endfunction
endpackage

module posit_fma_out_pipe #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int NUM_REGS = 2,
  localparam int unsigned WIDTH = posit_pkg::posit_width(pFormat)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   result_i,
  input  posit_pkg::status_t status_i,
  input  logic               tag_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               flush_i,
  output logic [WIDTH-1:0]   result_o,
  output posit_pkg::status_t status_o,
  output logic               tag_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o
);
  typedef enum logic {EMPTY, FULL} stage_e;
  if (NUM_REGS == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok   = ^{clk_i, rst_i, flush_i};
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign busy_o      = in_valid_i;
    assign result_o    = result_i;
    assign status_o    = status_i;
    assign tag_o       = tag_i;
  end else begin : g_pipe
    stage_e                   state_q   [NUM_REGS];
    stage_e                   state_d   [NUM_REGS];
    logic [WIDTH-1:0]         result_q  [NUM_REGS];
    logic [WIDTH-1:0]         up_result [NUM_REGS];
    posit_pkg::status_t       status_q  [NUM_REGS];
    posit_pkg::status_t       up_status [NUM_REGS];
    logic [NUM_REGS-1:0]      valid_q, up_valid, tag_q, up_tag;
    logic [NUM_REGS:0]        ready;
    for (genvar s = 0; s < NUM_REGS; s++) begin : g_stage
      assign valid_q[s] = state_q[s] == FULL;
      if (s == 0) begin : g_head
        assign up_valid[s]  = in_valid_i;
        assign up_result[s] = result_i;
        assign up_status[s] = status_i;
        assign up_tag[s]    = tag_i;
      end else begin : g_body
        assign up_valid[s]  = valid_q[s-1];
        assign up_result[s] = result_q[s-1];
        assign up_status[s] = status_q[s-1];
        assign up_tag[s]    = tag_q[s-1];
      end
    end
    // a stage can accept when it is empty or its contents move on this cycle, so bubbles collapse
    always_comb begin
      ready[NUM_REGS] = out_ready_i;
      for (int t = NUM_REGS - 1; t >= 0; t--) ready[t] = ready[t+1] | ~valid_q[t];
    end
    // per-stage EMPTY/FULL transition; flush empties everything, including a same-cycle input
    always_comb
      for (int t = 0; t < NUM_REGS; t++)
        state_d[t] = flush_i ? EMPTY : (up_valid[t] & ready[t]) ? FULL : ready[t+1] ? EMPTY : state_q[t];
    // state register plus payload that only loads on an accepted transfer
    always_ff @(posedge clk_i)
      if (rst_i) begin
        for (int t = 0; t < NUM_REGS; t++) begin
          state_q[t]  <= EMPTY;
          result_q[t] <= '0;
          status_q[t] <= '0;
          tag_q[t]    <= 1'b0;
        end
      end else begin
        for (int t = 0; t < NUM_REGS; t++) begin
          state_q[t] <= state_d[t];
          if (up_valid[t] & ready[t]) begin
            result_q[t] <= up_result[t];
            status_q[t] <= up_status[t];
            tag_q[t]    <= up_tag[t];
          end
        end
      end
    assign in_ready_o  = ready[0];
    assign out_valid_o = valid_q[NUM_REGS-1];
    assign busy_o      = |valid_q;
    assign result_o    = result_q[NUM_REGS-1];
    assign status_o    = status_q[NUM_REGS-1];
    assign tag_o       = tag_q[NUM_REGS-1];
  end
endmodule

// File: tb/tb_posit_fma_out_pipe.sv
// tb_posit_fma_out_pipe: directed vector checks for the 2-stage and pass-through builds
module tb_posit_fma_out_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, iv, ordy, tag, irdy, ov, tag_o, busy;
  logic [31:0] res, res_o;
  logic [4:0] st, st_o;
  logic zrst, zflush, ziv, zordy, ztag, zirdy, zov, ztag_o, zbusy;
  logic [31:0] zres, zres_o;
  logic [4:0] zst, zst_o;
  int checks = 0, errors = 0;

  posit_fma_out_pipe #(.NUM_REGS(2)) dut (
    .clk_i(clk), .rst_i(rst), .result_i(res), .status_i(st), .tag_i(tag),
    .in_valid_i(iv), .in_ready_o(irdy), .flush_i(flush), .result_o(res_o),
    .status_o(st_o), .tag_o(tag_o), .out_valid_o(ov), .out_ready_i(ordy), .busy_o(busy));

  posit_fma_out_pipe #(.NUM_REGS(0)) dut0 (
    .clk_i(clk), .rst_i(zrst), .result_i(zres), .status_i(zst), .tag_i(ztag),
    .in_valid_i(ziv), .in_ready_o(zirdy), .flush_i(zflush), .result_o(zres_o),
    .status_o(zst_o), .tag_o(ztag_o), .out_valid_o(zov), .out_ready_i(zordy), .busy_o(zbusy));

  typedef struct {
    logic rst, flush, iv;
    logic [31:0] res;
    logic [4:0] st;
    logic tag, ordy;
    logic e_irdy, e_ov, e_busy;
    logic [31:0] e_res;
    logic [4:0] e_st;
    logic e_tag;
  } vec_t;

  vec_t v [30];
  vec_t z [4];
  logic [37:0] q [$];

  initial begin
    // rst flush iv res st tag ordy | irdy ov busy res st tag  (outputs seen before the edge)
    v[0]  = '{0,0,1,32'h40000000,5'h02,1,1, 1,0,0,32'h0,5'h00,0};
    v[1]  = '{0,0,0,32'h0,5'h00,0,1,        1,0,1,32'h0,5'h00,0};
    v[2]  = '{0,0,0,32'h0,5'h00,0,1,        1,1,1,32'h40000000,5'h02,1};
    v[3]  = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'h40000000,5'h02,1};
    v[4]  = '{0,0,1,32'h1,5'h00,0,0,        1,0,0,32'h40000000,5'h02,1};
    v[5]  = '{0,0,1,32'h2,5'h00,0,0,        1,0,1,32'h40000000,5'h02,1};
    v[6]  = '{0,0,1,32'h3,5'h00,0,0,        0,1,1,32'h1,5'h00,0};
    v[7]  = '{0,0,1,32'h3,5'h00,0,1,        1,1,1,32'h1,5'h00,0};
    v[8]  = '{0,0,0,32'h0,5'h00,0,1,        1,1,1,32'h2,5'h00,0};
    v[9]  = '{0,0,0,32'h0,5'h00,0,1,        1,1,1,32'h3,5'h00,0};
    v[10] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'h3,5'h00,0};
    v[11] = '{0,0,1,32'h10,5'h10,1,0,       1,0,0,32'h3,5'h00,0};
    v[12] = '{0,0,0,32'h0,5'h00,0,0,        1,0,1,32'h3,5'h00,0};
    v[13] = '{0,0,1,32'h20,5'h05,0,0,       1,1,1,32'h10,5'h10,1};
    v[14] = '{0,0,0,32'h0,5'h00,0,0,        0,1,1,32'h10,5'h10,1};
    v[15] = '{0,0,0,32'h0,5'h00,0,1,        1,1,1,32'h10,5'h10,1};
    v[16] = '{0,0,0,32'h0,5'h00,0,1,        1,1,1,32'h20,5'h05,0};
    v[17] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'h20,5'h05,0};
    v[18] = '{0,0,1,32'ha1,5'h00,0,0,       1,0,0,32'h20,5'h05,0};
    v[19] = '{0,0,1,32'ha2,5'h00,0,0,       1,0,1,32'h20,5'h05,0};
    v[20] = '{0,1,1,32'ha3,5'h00,0,0,       0,1,1,32'ha1,5'h00,0};
    v[21] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'ha1,5'h00,0};
    v[22] = '{0,1,1,32'hb1,5'h00,0,1,       1,0,0,32'ha1,5'h00,0};
    v[23] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'ha1,5'h00,0};
    v[24] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'ha1,5'h00,0};
    v[25] = '{0,0,1,32'hc1,5'h1f,1,0,       1,0,0,32'ha1,5'h00,0};
    v[26] = '{0,0,1,32'hc2,5'h1f,1,0,       1,0,1,32'ha1,5'h00,0};
    v[27] = '{1,0,1,32'hc3,5'h1f,1,0,       0,1,1,32'hc1,5'h1f,1};
    v[28] = '{0,0,0,32'h0,5'h00,0,0,        1,0,0,32'h0,5'h00,0};
    v[29] = '{0,0,0,32'h0,5'h00,0,1,        1,0,0,32'h0,5'h00,0};
    z[0]  = '{0,0,1,32'h7fffffff,5'h01,1,1, 1,1,1,32'h7fffffff,5'h01,1};
    z[1]  = '{1,1,1,32'h80000000,5'h10,0,0, 0,1,1,32'h80000000,5'h10,0};
    z[2]  = '{0,0,0,32'h12345678,5'h0a,1,1, 1,0,0,32'h12345678,5'h0a,1};
    z[3]  = '{0,1,0,32'h0,5'h00,0,0,        0,0,0,32'h0,5'h00,0};

    {rst, flush, iv, ordy, tag, res, st} = '0;
    {zrst, zflush, ziv, zordy, ztag, zres, zst} = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      {zrst, zflush, ziv, zres, zst, ztag, zordy} = {z[i].rst, z[i].flush, z[i].iv, z[i].res, z[i].st, z[i].tag, z[i].ordy};
      #1;
      checks++;
      if ({zirdy, zov, zbusy, zres_o, zst_o, ztag_o} !== {z[i].e_irdy, z[i].e_ov, z[i].e_busy, z[i].e_res, z[i].e_st, z[i].e_tag}) begin
        errors++;
        $display("FAIL pass%0d: got irdy/ov/busy=%b%b%b res=%h st=%b tag=%b, want %b%b%b res=%h st=%b tag=%b", i,
                 zirdy, zov, zbusy, zres_o, zst_o, ztag_o, z[i].e_irdy, z[i].e_ov, z[i].e_busy, z[i].e_res, z[i].e_st, z[i].e_tag);
      end
    end

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      {rst, flush, iv, res, st, tag, ordy} = {v[i].rst, v[i].flush, v[i].iv, v[i].res, v[i].st, v[i].tag, v[i].ordy};
      #1;
      checks++;
      if ({irdy, ov, busy} !== {v[i].e_irdy, v[i].e_ov, v[i].e_busy}) begin
        errors++;
        $display("FAIL vec%0d ctrl: got irdy/ov/busy=%b%b%b, want %b%b%b", i, irdy, ov, busy, v[i].e_irdy, v[i].e_ov, v[i].e_busy);
      end
      checks++;
      if ({res_o, st_o, tag_o} !== {v[i].e_res, v[i].e_st, v[i].e_tag}) begin
        errors++;
        $display("FAIL vec%0d data: got res=%h st=%b tag=%b, want res=%h st=%b tag=%b", i, res_o, st_o, tag_o, v[i].e_res, v[i].e_st, v[i].e_tag);
      end
    end

    begin
      int sent, got, cyc;
      sent = 0;
      got = 0;
      cyc = 0;
      while (got < 8 && cyc < 200) begin
        @(negedge clk);
        {rst, flush} = 2'b00;
        iv = sent < 8;
        res = 32'h100 + sent;
        st = sent[4:0];
        tag = sent[0];
        ordy = (cyc % 3) != 1;
        #1;
        if (ov && ordy) begin
          checks++;
          if (q.size() == 0 || {tag_o, st_o, res_o} !== q[0]) begin
            errors++;
            $display("FAIL fifo out%0d: got tag=%b st=%b res=%h, want %h (queued %0d)", got, tag_o, st_o, res_o, q.size() ? q[0] : 38'h0, q.size());
          end
          if (q.size() != 0) void'(q.pop_front());
          got++;
        end
        if (iv && irdy) begin
          q.push_back({tag, st, res});
          sent++;
        end
        cyc++;
      end
      checks++;
      if (got != 8 || q.size() != 0) begin
        errors++;
        $display("FAIL fifo drain: got %0d ops with %0d left queued after %0d cycles, want 8 and 0", got, q.size(), cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
